// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Purpose  : Shared VGA pipeline constants, pixel bundle type and the
//            character pose enumeration used by the movement controller and
//            the character drawing stage.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

   localparam int          HOR_PIXELS  = 1024;
   localparam int          VER_PIXELS  = 768;
   localparam int          SPR_W_DEF   = 47;
   localparam int          SPR_H_DEF   = 63;
   localparam logic [11:0] KEY_RGB_DEF = 12'hF_0_F;
   localparam logic [11:0] BBOX_RGB    = 12'hF_0_0;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PREP  = 3'd1,
      JUMP  = 3'd2,
      LEFT  = 3'd3,
      RIGHT = 3'd4
   } character_skin_t;

   typedef struct packed {
      logic [11:0] hcount;
      logic [11:0] vcount;
      logic        hsync;
      logic        vsync;
      logic        hblnk;
      logic        vblnk;
      logic [11:0] rgb;
   } vga_pix_t;

   // Poses 5..7 are not defined by the controller; they fall back to idle.
   function automatic character_skin_t skin_sanitize(input logic [2:0] raw);
      character_skin_t s;
      case (raw)
         3'd0, 3'd1, 3'd2, 3'd3, 3'd4: s = character_skin_t'(raw);
         default:                      s = IDLE;
      endcase
      return s;
   endfunction

   // Walking poses pick their second image slot (5/6) on odd animation phase.
   function automatic logic [2:0] sprite_slot(input character_skin_t skin,
                                              input logic            phase);
      logic [2:0] slot;
      case (skin)
         LEFT:    slot = phase ? 3'd5 : 3'd3;
         RIGHT:   slot = phase ? 3'd6 : 3'd4;
         default: slot = 3'(skin);
      endcase
      return slot;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_if
// Purpose  : One VGA pixel-stream beat: timing counters, sync/blank strobes
//            and 12-bit colour. "in"/"slave" receive a stream, "out"/"master"
//            produce one.
// Revision : 1.0 - initial release
// ============================================================================
interface vga_if;
   logic [11:0] hcount;
   logic [11:0] vcount;
   logic        hsync;
   logic        vsync;
   logic        hblnk;
   logic        vblnk;
   logic [11:0] rgb;

   modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport in     (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport out    (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface
`default_nettype wire

// File: rtl/draw_character_rom.sv
`default_nettype none
// ============================================================================
// Module   : character_rom
// Purpose  : 32768 x 12 synchronous-read sprite store, one cycle latency.
//            Eight 64x64 image slots addressed as {slot, row, col}.
//            Slot 0 is solid blue; other slots encode {slot, row, col}
//            nibbles. Every pixel with row%8==5 and col%8==5 holds the
//            transparency key so see-through holes exist in every pose.
// Revision : 1.0 - initial release
// ============================================================================
module character_rom
   import vga_pkg::*;
#(
   parameter logic [11:0] KEY_RGB = KEY_RGB_DEF
)(
   input  logic        clk,
   input  logic [14:0] addr,
   output logic [11:0] data
);

   logic [2:0]  slot;
   logic [5:0]  row;
   logic [5:0]  col;
   logic [11:0] data_d;
   logic [11:0] data_q;

   // Image content as a function of the address fields.
   always_comb begin
      slot   = addr[14:12];
      row    = addr[11:6];
      col    = addr[5:0];
      data_d = {1'b0, slot, row[3:0], col[3:0]};
      if (row[2:0] == 3'd5 && col[2:0] == 3'd5) begin
         data_d = KEY_RGB;
      end else if (slot == 3'd0) begin
         data_d = 12'h0_0_F;
      end
   end

   // Registered read port.
   always_ff @(posedge clk) begin
      data_q <= data_d;
   end

   assign data = data_q;

endmodule
`default_nettype wire

// File: rtl/draw_character.sv
`default_nettype none
// ============================================================================
// Module   : draw_character
// Purpose  : Overlays a SPR_W x SPR_H character sprite onto the background
//            VGA stream. Position and pose are latched at frame start so the
//            sprite never tears; walking poses alternate between two images
//            every ANIM_FRAMES frames. Two-cycle latency on every field.
//            Optional macro DRAW_CHARACTER_BBOX_EN draws the sprite box
//            outline in red for hitbox debugging.
// Revision : 1.0 - initial release
// ============================================================================
module draw_character
   import vga_pkg::*;
#(
   parameter int          SPR_W       = SPR_W_DEF,
   parameter int          SPR_H       = SPR_H_DEF,
   parameter logic [11:0] KEY_RGB     = KEY_RGB_DEF,
   parameter int          ANIM_FRAMES = 8
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] value_x,
   input  logic [11:0] value_y,
   input  logic [2:0]  character_skin,
   vga_if.in           vga_in,
   vga_if.out          vga_out
);

   localparam int ACW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

   // Frame-latched position/pose and walk animation state.
   logic [11:0]     lx_d, lx_q;
   logic [11:0]     ly_d, ly_q;
   character_skin_t lskin_d, lskin_q;
   logic [ACW-1:0]  anim_cnt_d, anim_cnt_q;
   logic            anim_phase_d, anim_phase_q;

   // Pipeline.
   vga_pix_t        s1_d, s1_q;
   vga_pix_t        out_d, out_q;
   logic            in_box_d, in_box_q;
   logic [14:0]     rom_addr;
   logic [11:0]     rom_data;

   logic            frame_start;
   character_skin_t skin_in;
   logic [12:0]     hc13, vc13, x_lo, x_hi, y_lo, y_hi;
   logic [5:0]      col, row;

`ifdef DRAW_CHARACTER_BBOX_EN
   logic            edge_d, edge_q;
`endif

   // Frame latch and animation counter update at pixel (0,0).
   always_comb begin
      frame_start  = (vga_in.hcount == 12'd0) && (vga_in.vcount == 12'd0);
      skin_in      = skin_sanitize(character_skin);
      lx_d         = lx_q;
      ly_d         = ly_q;
      lskin_d      = lskin_q;
      anim_cnt_d   = anim_cnt_q;
      anim_phase_d = anim_phase_q;
      if (frame_start) begin
         lx_d    = value_x;
         ly_d    = value_y;
         lskin_d = skin_in;
         if (skin_in == LEFT || skin_in == RIGHT) begin
            if (anim_cnt_q == ACW'(ANIM_FRAMES - 1)) begin
               anim_cnt_d   = '0;
               anim_phase_d = ~anim_phase_q;
            end else begin
               anim_cnt_d   = anim_cnt_q + 1'b1;
            end
         end else begin
            anim_cnt_d   = '0;
            anim_phase_d = 1'b0;
         end
      end
   end

   // Stage 1: box test in 13 bits so a box straddling 4095 never wraps,
   // and ROM address formation. The ROM's own register is the stage-1 data.
   always_comb begin
      hc13     = {1'b0, vga_in.hcount};
      vc13     = {1'b0, vga_in.vcount};
      x_lo     = {1'b0, lx_q};
      y_lo     = {1'b0, ly_q};
      x_hi     = x_lo + 13'(SPR_W);
      y_hi     = y_lo + 13'(SPR_H);
      in_box_d = (hc13 >= x_lo) && (hc13 < x_hi) &&
                 (vc13 >= y_lo) && (vc13 < y_hi) &&
                 !vga_in.hblnk && !vga_in.vblnk;
      col      = 6'(vga_in.hcount - lx_q);
      row      = 6'(vga_in.vcount - ly_q);
      rom_addr = {sprite_slot(lskin_q, anim_phase_q), row, col};
      s1_d     = '{hcount: vga_in.hcount, vcount: vga_in.vcount,
                   hsync:  vga_in.hsync,  vsync:  vga_in.vsync,
                   hblnk:  vga_in.hblnk,  vblnk:  vga_in.vblnk,
                   rgb:    vga_in.rgb};
`ifdef DRAW_CHARACTER_BBOX_EN
      edge_d   = in_box_d && ((row == 6'd0) || (row == 6'(SPR_H - 1)) ||
                              (col == 6'd0) || (col == 6'(SPR_W - 1)));
`endif
   end

   // Stage 2: opaque sprite pixels replace the background.
   always_comb begin
      out_d = s1_q;
      if (in_box_q && (rom_data != KEY_RGB)) begin
         out_d.rgb = rom_data;
      end
`ifdef DRAW_CHARACTER_BBOX_EN
      if (edge_q) begin
         out_d.rgb = BBOX_RGB;
      end
`endif
   end

   // State and pipeline registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         lx_q         <= '0;
         ly_q         <= '0;
         lskin_q      <= IDLE;
         anim_cnt_q   <= '0;
         anim_phase_q <= 1'b0;
         s1_q         <= '0;
         out_q        <= '0;
         in_box_q     <= 1'b0;
`ifdef DRAW_CHARACTER_BBOX_EN
         edge_q       <= 1'b0;
`endif
      end else begin
         lx_q         <= lx_d;
         ly_q         <= ly_d;
         lskin_q      <= lskin_d;
         anim_cnt_q   <= anim_cnt_d;
         anim_phase_q <= anim_phase_d;
         s1_q         <= s1_d;
         out_q        <= out_d;
         in_box_q     <= in_box_d;
`ifdef DRAW_CHARACTER_BBOX_EN
         edge_q       <= edge_d;
`endif
      end
   end

   character_rom #(.KEY_RGB(KEY_RGB)) u_rom (
      .clk  (clk),
      .addr (rom_addr),
      .data (rom_data)
   );

   assign vga_out.hcount = out_q.hcount;
   assign vga_out.vcount = out_q.vcount;
   assign vga_out.hsync  = out_q.hsync;
   assign vga_out.vsync  = out_q.vsync;
   assign vga_out.hblnk  = out_q.hblnk;
   assign vga_out.vblnk  = out_q.vblnk;
   assign vga_out.rgb    = out_q.rgb;

endmodule
`default_nettype wire

// File: tb/tb_draw_character.sv
`default_nettype none
// ============================================================================
// Module   : tb_draw_character
// Purpose  : Self-checking bench for draw_character. A behavioural model of
//            the sprite overlay predicts every output beat; directed probes
//            check the documented scenarios, then randomized traffic runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_draw_character;

   typedef struct packed {
      logic [11:0] hcount;
      logic [11:0] vcount;
      logic        hsync;
      logic        vsync;
      logic        hblnk;
      logic        vblnk;
      logic [11:0] rgb;
   } pix_t;

   localparam int          W   = 47;
   localparam int          H   = 63;
   localparam logic [11:0] KEY = 12'hF0F;
   localparam logic [11:0] BG  = 12'h2B4;
`ifdef DRAW_CHARACTER_BBOX_EN
   localparam logic [11:0] EDGE_BLUE = 12'hF00;
`else
   localparam logic [11:0] EDGE_BLUE = 12'h00F;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] value_x, value_y;
   logic [2:0]  skin;
   int          vectors = 0;
   int          miscompares = 0;

   // Reference model state.
   int   mlx, mly, mskin, mcnt, mphase;
   pix_t d1, d2;

   vga_if vin ();
   vga_if vout ();

   draw_character dut (
      .clk            (clk),
      .rst            (rst),
      .value_x        (value_x),
      .value_y        (value_y),
      .character_skin (skin),
      .vga_in         (vin),
      .vga_out        (vout)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] sprite_word(int slot, int r, int c);
      if ((r % 8) == 5 && (c % 8) == 5) return KEY;
      if (slot == 0) return 12'h00F;
      return 12'(slot * 256 + (r % 16) * 16 + (c % 16));
   endfunction

   function automatic pix_t model_pixel(int hc, int vc, logic hb, logic vb,
                                        logic [11:0] rgb);
      pix_t p;
      int   slot, r, c;
      logic [11:0] w;
      p = '{hcount: 12'(hc), vcount: 12'(vc), hsync: 1'(hc / 16),
            vsync: 1'(vc / 2), hblnk: hb, vblnk: vb, rgb: rgb};
      if (!hb && !vb && hc >= mlx && hc < mlx + W && vc >= mly && vc < mly + H) begin
         c = hc - mlx;
         r = vc - mly;
         slot = mskin;
         if (mskin == 3 && mphase == 1) slot = 5;
         if (mskin == 4 && mphase == 1) slot = 6;
         w = sprite_word(slot, r, c);
         if (w != KEY) p.rgb = w;
`ifdef DRAW_CHARACTER_BBOX_EN
         if (r == 0 || r == H - 1 || c == 0 || c == W - 1) p.rgb = 12'hF00;
`endif
      end
      return p;
   endfunction

   task automatic step(input logic r, input int hc, input int vc,
                       input logic hb, input logic vb, input logic [11:0] rgb);
      pix_t act;
      int   sk;
      @(negedge clk);
      rst        = r;
      vin.hcount = 12'(hc);
      vin.vcount = 12'(vc);
      vin.hsync  = 1'(hc / 16);
      vin.vsync  = 1'(vc / 2);
      vin.hblnk  = hb;
      vin.vblnk  = vb;
      vin.rgb    = rgb;
      if (r) begin
         d1 = '0; d2 = '0;
         mlx = 0; mly = 0; mskin = 0; mcnt = 0; mphase = 0;
      end else begin
         d2 = d1;
         d1 = model_pixel(hc, vc, hb, vb, rgb);
         if (hc == 0 && vc == 0) begin
            mlx = int'(value_x);
            mly = int'(value_y);
            sk  = int'(skin);
            mskin = (sk > 4) ? 0 : sk;
            if (mskin == 3 || mskin == 4) begin
               mcnt = mcnt + 1;
               if (mcnt == 8) begin
                  mcnt = 0;
                  mphase = 1 - mphase;
               end
            end else begin
               mcnt = 0;
               mphase = 0;
            end
         end
      end
      @(posedge clk);
      #1;
      act = {vout.hcount, vout.vcount, vout.hsync, vout.vsync,
             vout.hblnk, vout.vblnk, vout.rgb};
      vectors++;
      assert (act === d2) else begin
         miscompares++;
         $error("FAIL pipe_beat observed=%h expected=%h", act, d2);
      end
   endtask

   task automatic px(input int hc, input int vc, input logic [11:0] rgb);
      step(1'b0, hc, vc, 1'b0, 1'b0, rgb);
   endtask

   task automatic frame_start();
      step(1'b0, 0, 0, 1'b0, 1'b0, BG);
   endtask

   // Drive one pixel, then one filler beat, then check that pixel's colour.
   task automatic probe(input string tag, input int hc, input int vc,
                        input logic hb, input logic [11:0] exp);
      step(1'b0, hc, vc, hb, 1'b0, BG);
      step(1'b0, 1500, 1500, 1'b1, 1'b1, 12'h000);
      vectors++;
      assert (vout.rgb === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, vout.rgb, exp);
      end
   endtask

   initial begin
      value_x = 12'd70;
      value_y = 12'd353;
      skin    = 3'd0;

      // Reset state.
      step(1'b1, 5, 5, 1'b0, 1'b0, BG);
      step(1'b1, 6, 5, 1'b0, 1'b0, BG);
      vectors++;
      assert (vout.rgb === 12'h000 && vout.hcount === 12'h000) else begin
         miscompares++;
         $error("FAIL reset_out observed=%h expected=000", vout.rgb);
      end

      // Basic overlay at (70,353).
      frame_start();
      probe("sprite_origin", 70, 353, 1'b0, EDGE_BLUE);
      probe("left_of_box",   69, 353, 1'b0, BG);
      probe("right_of_box", 117, 353, 1'b0, BG);
      probe("last_col",     116, 353, 1'b0, EDGE_BLUE);
      probe("key_hole",      75, 358, 1'b0, BG);
      probe("inside",        80, 363, 1'b0, 12'h00F);
      probe("last_row",      80, 415, 1'b0, EDGE_BLUE);
      probe("below_box",     80, 416, 1'b0, BG);
      probe("hblank_inside", 80, 363, 1'b1, BG);

      // Mid-frame position change has no effect until next frame.
      value_x = 12'd200;
      px(300, 100, BG);
      probe("midframe_old",  80, 363, 1'b0, 12'h00F);
      probe("midframe_new", 210, 363, 1'b0, BG);
      frame_start();
      probe("nextframe_new", 210, 363, 1'b0, 12'h00F);
      probe("nextframe_old",  80, 363, 1'b0, BG);

      // Walk animation: slot 3/5 alternate every 8 frames.
      value_x = 12'd70;
      skin    = 3'd3;
      for (int n = 1; n <= 18; n++) begin
         frame_start();
         probe("walk_left", 80, 363, 1'b0, ((n / 8) % 2 == 1) ? 12'h5AA : 12'h3AA);
      end
      skin = 3'd0;
      frame_start();
      probe("back_to_idle", 80, 363, 1'b0, 12'h00F);
      skin = 3'd4;
      frame_start();
      probe("walk_right", 80, 363, 1'b0, 12'h4AA);
      skin = 3'd6;
      frame_start();
      probe("invalid_skin", 80, 363, 1'b0, 12'h00F);

      // Clipping at the right/bottom edges, no wrap to 0.
      skin    = 3'd0;
      value_x = 12'd1000;
      value_y = 12'd700;
      frame_start();
      probe("clip_right_col", 1023, 710, 1'b0, 12'h00F);
      probe("clip_bottom_row", 1010, 762, 1'b0, EDGE_BLUE);
      probe("clip_past_row",  1010, 763, 1'b0, BG);
      probe("clip_no_col0",      5, 710, 1'b0, BG);
      probe("clip_no_row0",   1010,   5, 1'b0, BG);
      value_x = 12'd4090;
      frame_start();
      probe("no_13bit_wrap",    10, 710, 1'b0, BG);

      // Reset mid-line: two zero beats, then pass-through with sprite at (0,0).
      px(300, 200, BG);
      step(1'b1, 301, 200, 1'b0, 1'b0, BG);
      vectors++;
      assert (vout.rgb === 12'h000 && vout.hcount === 12'h000) else begin
         miscompares++;
         $error("FAIL rst_zero1 observed=%h expected=000", vout.rgb);
      end
      px(302, 200, BG);
      vectors++;
      assert (vout.rgb === 12'h000 && vout.vcount === 12'h000) else begin
         miscompares++;
         $error("FAIL rst_zero2 observed=%h expected=000", vout.rgb);
      end
      probe("post_rst_passthru", 500, 200, 1'b0, BG);
      probe("post_rst_origin",     3,   3, 1'b0, 12'h00F);

      // Randomized traffic against the model.
      for (int i = 0; i < 1600; i++) begin
         int hc, vc;
         logic r, hb, vb;
         if (i % 100 == 0) begin
            value_x = 12'($urandom_range(0, 1100));
            value_y = 12'($urandom_range(0, 800));
            skin    = 3'($urandom_range(0, 7));
         end
         r  = ($urandom_range(0, 199) == 0);
         hb = ($urandom_range(0, 7) == 0);
         vb = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 29) == 0) begin
            hc = 0; vc = 0;
         end else if ($urandom_range(0, 1) == 0) begin
            hc = $urandom_range(0, 1200);
            vc = $urandom_range(0, 900);
         end else begin
            hc = (mlx + $urandom_range(0, 56) + 4096 - 4) % 4096;
            vc = (mly + $urandom_range(0, 72) + 4096 - 4) % 4096;
         end
         step(r, hc, vc, hb, vb, 12'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/draw_character.md
Name: draw_character

Overview:
- Downstream stage of the character movement controller in the VGA pixel pipeline.
- Consumes the character position (value_x/value_y) and pose (character_skin) and overlays a 47x63 sprite fetched from a sprite ROM onto the incoming background stream.
- Transparent sprite pixels pass the background through.
- Position and pose are sampled once per frame, so the sprite never tears mid-frame.
- Walking poses get a two-phase animation.

Parameters:
- SPR_W, 47, sprite width in pixels (≤64)
- SPR_H, 63, sprite height in pixels (≤64)
- KEY_RGB, 12'hF_0_F, ROM colour treated as transparent
- ANIM_FRAMES, 8, video frames per walk-animation phase (≥1)

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset; synchronous, active-high
- value_x  in  12  sprite left column (from movement controller)
- value_y  in  12  sprite top row
- character_skin  in  3  pose: 0 idle, 1 prep, 2 jump, 3 left, 4 right; 5–7 invalid
- vga_in  vga_if.in  –  background timing + rgb
- vga_out  vga_if.out  –  timing delayed 2 cycles, rgb with sprite overlaid

Behaviour:
- Reset: all vga_out fields 0; latched x/y/skin 0; anim counter 0; anim phase 0; pipeline registers 0.
- Frame latch: on the cycle vga_in.hcount==0 && vga_in.vcount==0, capture value_x, value_y and character_skin into lx, ly, lskin.
  - Same cycle, walk animation update:
    - If the new skin is 3 or 4: anim_cnt increments; on reaching ANIM_FRAMES-1 it wraps to 0 and anim_phase toggles.
    - Otherwise anim_cnt and anim_phase clear to 0.
  - Before the first latch after reset, the sprite draws at (0,0) with skin 0.
- Invalid skin (5–7) latches as 0.
- Stage 1 (registered):
  - in_box = hc ≥ lx && hc < lx+SPR_W && vc ≥ ly && vc < ly+SPR_H && !hblnk && !vblnk.
  - Comparisons are done in 13 bits, so lx+SPR_W beyond 4095 never wraps.
  - col = hc-lx and row = vc-ly, each 6 bits.
  - ROM address = {img[2:0], row[5:0], col[5:0]} (15 bits).
  - img = lskin for skins 0–2. Skin 3 → img 3 (phase 0) or 5 (phase 1). Skin 4 → img 4 or 6.
  - Timing signals and rgb are delayed alongside.
- Stage 2 (registered): the ROM returns data one cycle after the address.
  - vga_out.rgb = (in_box_d && rom_data != KEY_RGB) ? rom_data : rgb_d.
  - hcount, vcount, hsync, vsync, hblnk and vblnk are forwarded unchanged.
- Latency: exactly 2 clk from vga_in to vga_out for every field.
- Boundaries:
  - Partial off-screen sprite (lx > HOR_PIXELS-SPR_W, or ly > VER_PIXELS-SPR_H) clips naturally; no wrap to column/row 0.
  - Pixels in blanking are never modified.
  - Changes to value_x/value_y/skin mid-frame have no effect until the next frame latch.
  - rst mid-frame clears the pipeline; output is 0 for 2 cycles, then background pass-through resumes.

Optional Feature:
- Macro: DRAW_CHARACTER_BBOX_EN.
- Defined: the outline of the latched SPR_W x SPR_H box is drawn in 12'hF_0_0, overriding both sprite and background, for hitbox debugging.
  - Outline = row 0, row SPR_H-1, col 0, col SPR_W-1.
  - The outline obeys the same latency and blanking rules.
- Undefined: no outline logic is synthesised; behaviour is exactly as above.

Decomposition:
- vga_pkg holds:
  - HOR_PIXELS, VER_PIXELS;
  - a new character_skin_t enum (IDLE/PREP/JUMP/LEFT/RIGHT), shared with the movement controller;
  - the SPR_W/SPR_H defaults;
  - the transparency key constant.
- One sub-module, character_rom: 32768x12 synchronous-read ROM, 1-cycle latency, initialised from a .dat file with 8 slots of 64x64.

Test Plan:
- Background const 12'h2_B_4, value_x=70, value_y=353, skin 0, ROM slot 0 filled 12'h00F:
  - pixel (70,353) outputs 12'h00F two cycles after it enters;
  - (69,353) and (117,353) output 12'h2_B_4.
- ROM pixel at (row 5, col 5) = KEY_RGB → background 12'h2_B_4 passes at screen (75,358).
- value_x changed from 70 to 200 at vcount=100 → rest of the frame still drawn at 70; the next frame draws at 200.
- Skin 3 held, ANIM_FRAMES=8 → image slot alternates 3/5 every 8 frames; switching to skin 0 → slot 0, anim_cnt 0.
- value_x=1000, value_y=700 → only on-screen columns 1000..1023 and rows 700..762 within the visible area show sprite; no sprite pixels appear at column 0 or row 0.
- rst asserted for 1 cycle mid-line → vga_out all 0 for the next 2 cycles, then exact background pass-through; sprite at (0,0), skin 0, until the next frame start.
